crypto_seq_ctrl: RTL and testbench
==================================

Name: crypto_seq_ctrl

Overview:
- Sequencer for the byte-chained XOR cipher (encrypt/decrypt, 32-bit word, 8-bit IV, 32-bit key).
- Accepts one word per valid/ready handshake and steps an internal byte counter 0..3, one byte per clock.
- Accumulates the result in a register and presents it on a valid/ready output.
- Sits between the host/bus interface and downstream consumers; owns the key register and the step count.

Parameters:
- IV, 8'h9B, initial chaining byte for byte 0
- CNT_W, 16, width of completed-word counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- key_we  in  1  load key register (honoured only in IDLE)
- key_in  in  32  key value
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  32  plaintext (mode=0) or ciphertext (mode=1)
- in_mode  in  1  0=encrypt, 1=decrypt; latched at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  result word
- busy  out  1  state != IDLE
- step  out  2  current byte index (debug)
- word_cnt  out  CNT_W  completed words; wraps modulo 2^CNT_W
- chain_clr  in  1  reset chaining byte to IV (used only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, step=0, word_cnt=0, key=0, chain byte=IV.
- A reset asserted mid-operation discards the in-flight word. No output handshake occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid: latch in_data, in_mode and key; clear the accumulator; step=0; go to RUN.
  - If key_we and in_valid are both high in the same cycle, the word is encrypted with the new key_in.
- RUN:
  - in_ready=0.
  - Each cycle computes byte i=step and writes result byte i. All other bytes hold.
  - step increments each cycle. After step=3, go to DONE and do not wrap step.
- Byte equations (p=input byte, k=key byte, r=result byte, c0prev=chain byte):
  - Encrypt: r0=c0prev^p0^k0; ri=r(i-1)^pi^ki.
  - Decrypt: r0=c0prev^p0^k0; ri=p(i-1)^pi^ki.
  - Decrypt is the exact inverse of encrypt for the same key and chain byte.
- DONE:
  - out_valid=1, out_data=accumulator, held stable until out_ready.
  - On out_valid&out_ready: word_cnt+1 (wrapping), go to IDLE.
  - No accept in the same cycle; back-to-back throughput is 1 word per 6 cycles minimum.
- Latency: accept on edge T; out_valid high after edge T+4 (4 RUN cycles).
- key_we outside IDLE is ignored. The key in use never changes during a word.
- in_mode and in_data changes after accept have no effect.
- Without the optional feature, the chain byte is always IV.

Optional Feature:
- Macro CRYPTO_SEQ_CHAIN_EN.
- Defined:
  - The chain byte becomes the last ciphertext byte of the previous completed word: out_data[31:24] when encrypting, latched in_data[31:24] when decrypting.
  - It updates at the output handshake.
  - chain_clr (sampled any cycle) restores it to IV; chain_clr in the same cycle as a handshake wins.
  - Reset restores IV.
- Undefined: chain byte fixed at IV; chain_clr ignored.

Test Plan:
- Reset, key_we key_in=0, encrypt 0x00000000 -> out_data=0x9B9B9B9B, out_valid after 4 RUN cycles, word_cnt=1.
- key=0x10203040, encrypt 0x04030201 -> 0xDFCBE8DA.
- Decrypt 0xDFCBE8DA with the same key -> 0x04030201.
- Hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, extra in_valid not accepted; key_we during RUN leaves key unchanged for the next word.
- Assert rst_n=0 during RUN step=2 -> next cycle IDLE, out_valid=0, out_data=0, word_cnt=0.
- CRYPTO_SEQ_CHAIN_EN defined:
  - Encrypt 0x04030201 then 0x00000000, key 0x10203040 -> 0xDFCBE8DA then 0x9F8FAF9F.
  - Pulse chain_clr, re-encrypt 0x04030201 -> 0xDFCBE8DA.

Source files
------------

// File: rtl/crypto_seq_ctrl.sv
// Byte-chained XOR cipher sequencer: one 32-bit word per handshake, one byte per clock.
// Optional macro CRYPTO_SEQ_CHAIN_EN carries the last ciphertext byte across words.
module crypto_seq_ctrl #(
  parameter logic [7:0] IV    = 8'h9B,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_we,
  input  logic [31:0]      key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic [1:0]       step,
  output logic [CNT_W-1:0] word_cnt,
  input  logic             chain_clr
);

  // state   | meaning
  // S_IDLE  | waiting for a word; key register writable
  // S_RUN   | computing byte step_q, one per clock
  // S_DONE  | result presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      key_q, key_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept, hs;
  logic [1:0] step_m1;
  logic [7:0] chain_b, p_b, k_b, prev_b, r_b;

  assign accept  = (state_q == S_IDLE) && in_valid;
  assign hs      = (state_q == S_DONE) && out_ready;
  assign step_m1 = step_q - 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (step_q == 2'd3) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign out_data = acc_q;
  assign step     = step_q;
  assign word_cnt = cnt_q;

  // Byte 0 chains from the chain byte; later bytes from the previous ciphertext byte,
  // which is the result when encrypting and the latched input when decrypting.
  always_comb begin
    p_b    = data_q[{step_q, 3'b000} +: 8];
    k_b    = key_q[{step_q, 3'b000} +: 8];
    prev_b = chain_b;
    if (step_q != 2'd0) begin
      prev_b = mode_q ? data_q[{step_m1, 3'b000} +: 8] : acc_q[{step_m1, 3'b000} +: 8];
    end
    r_b = prev_b ^ p_b ^ k_b;
  end

  always_comb begin
    key_d  = key_q;
    data_d = data_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    if (state_q == S_IDLE && key_we) key_d = key_in;
    if (accept) begin
      data_d = in_data;
      mode_d = in_mode;
      acc_d  = '0;
      step_d = 2'd0;
    end else if (state_q == S_RUN) begin
      acc_d[{step_q, 3'b000} +: 8] = r_b;
      if (step_q != 2'd3) step_d = step_q + 2'd1;
    end
    if (hs) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q  <= '0;
      data_q <= '0;
      mode_q <= 1'b0;
      acc_q  <= '0;
      step_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      key_q  <= key_d;
      data_q <= data_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef CRYPTO_SEQ_CHAIN_EN
  logic [7:0] chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (chain_clr) begin
      chain_d = IV;
    end else if (hs) begin
      chain_d = mode_q ? data_q[31:24] : acc_q[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= IV;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign chain_b = chain_q;
`else
  logic unused_chain_clr;
  assign unused_chain_clr = chain_clr;
  assign chain_b          = IV;
`endif

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Scoreboard bench for crypto_seq_ctrl; chain tests follow CRYPTO_SEQ_CHAIN_EN.
module tb_crypto_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, key_we, in_valid, in_ready, in_mode, out_valid, out_ready, busy, chain_clr;
  logic [31:0] key_in, in_data, out_data;
  logic [1:0]  step;
  logic [15:0] word_cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  int          exp_cnt     = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  crypto_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .step(step), .word_cnt(word_cnt), .chain_clr(chain_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
      exp_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic mode, input logic [31:0] exp,
                      input logic load_key, input logic [31:0] key, input logic poke_run);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    key_we   = load_key;
    key_in   = key;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    key_we   = poke_run;
    key_in   = 32'hFFFF_FFFF;
    in_data  = 32'hA5A5_A5A5;
    in_mode  = ~mode;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    key_we = 1'b0;
    check("latency", 32'(n), 32'd4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
    check("word_cnt", {16'd0, word_cnt}, 32'(exp_cnt));
  endtask

  task automatic clr_chain();
    chain_clr = 1'b1;
    tick();
    chain_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; key_we = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0;
    in_mode = 1'b0; out_ready = 1'b1; chain_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_step",      {30'd0, step},      32'd0);
    check("rst_word_cnt",  {16'd0, word_cnt},  32'd0);

    key_we = 1'b1; key_in = 32'd0;
    tick();
    key_we = 1'b0;
    send(32'h0000_0000, 1'b0, 32'h9B9B_9B9B, 1'b0, 32'd0, 1'b0);
    drain();

    // Key written in the same cycle as the accept takes effect for that word.
    send(32'h0403_0201, 1'b0, 32'hDFCB_E8DA, 1'b1, 32'h1020_3040, 1'b0);
    drain();
    clr_chain();
    send(32'hDFCB_E8DA, 1'b1, 32'h0403_0201, 1'b0, 32'd0, 1'b0);
    drain();
    clr_chain();

    // Backpressure in DONE, with a key write attempted during RUN.
    out_ready = 1'b0;
    send(32'h1122_3344, 1'b0, 32'h9F9E_9C9F, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      tick();
      check("hold_out_data",  out_data,            32'h9F9E_9C9F);
      check("hold_out_valid", {31'd0, out_valid},  32'd1);
      check("hold_in_ready",  {31'd0, in_ready},   32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    clr_chain();
    send(32'h0403_0201, 1'b0, 32'hDFCB_E8DA, 1'b0, 32'd0, 1'b0);
    drain();

    // Reset while step == 2 drops the in-flight word.
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_mode  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("step_before_reset", {30'd0, step}, 32'd2);
    rst_n = 1'b0;
    tick();
    exp_cnt = 0;
    check("midrst_busy",      {31'd0, busy},      32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data",  out_data,           32'd0);
    check("midrst_word_cnt",  {16'd0, word_cnt},  32'd0);
    check("midrst_step",      {30'd0, step},      32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Key register was cleared by reset.
    send(32'h0000_0000, 1'b0, 32'h9B9B_9B9B, 1'b0, 32'd0, 1'b0);
    drain();

`ifdef CRYPTO_SEQ_CHAIN_EN
    send(32'h0403_0201, 1'b0, 32'hDFCB_E8DA, 1'b1, 32'h1020_3040, 1'b0);
    drain();
    send(32'h0000_0000, 1'b0, 32'h9F8F_AF9F, 1'b0, 32'd0, 1'b0);
    drain();
    clr_chain();
    send(32'h0403_0201, 1'b0, 32'hDFCB_E8DA, 1'b0, 32'd0, 1'b0);
    drain();
    send(32'h9F8F_AF9F, 1'b1, 32'h0000_0000, 1'b0, 32'd0, 1'b0);
    drain();
`else
    send(32'h0403_0201, 1'b0, 32'hDFCB_E8DA, 1'b1, 32'h1020_3040, 1'b0);
    drain();
    send(32'h0000_0000, 1'b0, 32'hDBCB_EBDB, 1'b0, 32'd0, 1'b0);
    drain();
    clr_chain();
    send(32'h0403_0201, 1'b0, 32'hDFCB_E8DA, 1'b0, 32'd0, 1'b0);
    drain();
`endif

    tick(); tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
